// File: rtl/audio_pkg.sv
// Shared widths, UART state encoding and the oscillator mixer for the synth board.
package audio_pkg;

    localparam int SAMPLE_W = 8;
    localparam int PHASE_W  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Average of the two oscillators; the 9-bit sum keeps the full range before halving.
    function automatic logic [SAMPLE_W-1:0] mix(input logic [SAMPLE_W-1:0] saw,
                                                input logic [SAMPLE_W-1:0] sq);
        logic [SAMPLE_W:0] sum;
        sum = {1'b0, saw} + {1'b0, sq};
        return sum[SAMPLE_W:1];
    endfunction

endpackage

// File: rtl/audio_engine_uart_tx.sv
// 8N1 UART transmitter with registered tx/busy; a load request while busy is ignored.
//
// state | meaning
// IDLE  | line idle high, waiting for valid
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high), then back to IDLE
module uart_tx
    import audio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       busy,
    output logic       tx
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_STOP  = STOP;

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    state;
    logic [CW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tc;

    assign tc = (timer == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        state <= S_START;
                        timer <= BIT_LOAD;
                        shreg <= data;
                    end
                end
                S_START: begin
                    if (tc) begin
                        state   <= S_DATA;
                        timer   <= BIT_LOAD;
                        bit_idx <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tc) begin
                        timer <= BIT_LOAD;
                        shreg <= shreg >> 1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_STOP: begin
                    if (tc) state <= S_IDLE;
                    else    timer <= timer - 1'b1;
                end
                default: state <= S_IDLE;
            endcase

            // Line level follows the state one cycle later so every output is a flop.
            tx   <= (state == S_START) ? 1'b0 :
                    (state == S_DATA)  ? shreg[0] : 1'b1;
            busy <= (state != S_IDLE);
        end
    end

endmodule

// File: rtl/audio_engine.sv
// Two phase-accumulator oscillators mixed per sample tick and streamed as UART bytes.
module audio_engine
    import audio_pkg::*;
#(
    parameter int                 CLKS_PER_BIT  = 12,
    parameter int                 SAMPLE_DIV    = 272,
    parameter logic [PHASE_W-1:0] PHASE_INC_A   = 24'h00_2A00,
    parameter logic [PHASE_W-1:0] PHASE_INC_B   = 24'h00_1500,
    parameter int                 HEARTBEAT_BIT = 22
) (
    input  logic clk,
    input  logic rst_n,
    output logic led1,
    output logic led2,
    output logic led8,
    output logic ftdi_tx
);

    localparam int SCW = $clog2(SAMPLE_DIV);

    logic [SCW-1:0]      sample_cnt;
    logic                tick;
    logic [PHASE_W-1:0]  phase_a;
    logic [PHASE_W-1:0]  phase_b;
    logic [31:0]         heartbeat;
    logic [SAMPLE_W-1:0] saw;
    logic [SAMPLE_W-1:0] sq;
    logic [SAMPLE_W-1:0] sample;
    logic                uart_busy;

    assign tick   = (sample_cnt == SCW'(SAMPLE_DIV - 1));
    assign saw    = phase_a[PHASE_W-1 -: SAMPLE_W];
    assign sq     = phase_b[PHASE_W-1] ? 8'hFF : 8'h00;
    assign sample = mix(saw, sq);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            phase_a    <= '0;
            phase_b    <= '0;
            heartbeat  <= '0;
            led1       <= 1'b0;
            led8       <= 1'b0;
        end else begin
            sample_cnt <= tick ? '0 : sample_cnt + 1'b1;
            heartbeat  <= heartbeat + 32'd1;
            // The UART latches the mix of the pre-update phases on this same edge.
            if (tick) begin
                phase_a <= phase_a + PHASE_INC_A;
                phase_b <= phase_b + PHASE_INC_B;
            end
            led1 <= phase_b[PHASE_W-1];
            led8 <= heartbeat[HEARTBEAT_BIT];
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .data (sample),
        .valid(tick),
        .busy (uart_busy),
        .tx   (ftdi_tx)
    );

    assign led2 = uart_busy;

endmodule

// File: tb/tb_audio_engine.sv
// Bench for audio_engine: two parameterisations checked cycle-by-cycle against a frame-level model.
module tb_audio_engine;

    localparam int          SD     = 272;
    localparam int          CPB    = 12;
    localparam int          FRAME  = 10 * CPB;
    localparam logic [23:0] INCA_A = 24'h02_0000;
    localparam logic [23:0] INCB_A = 24'h80_0000;
    localparam int          HB_A   = 4;
    localparam logic [23:0] INCA_B = 24'h13_5A73;
    localparam logic [23:0] INCB_B = 24'h0B_1F05;
    localparam int          HB_B   = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic led1_a, led2_a, led8_a, tx_a;
    logic led1_b, led2_b, led8_b, tx_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = -1;

    always #5 clk = ~clk;

    audio_engine #(
        .CLKS_PER_BIT(CPB), .SAMPLE_DIV(SD), .PHASE_INC_A(INCA_A),
        .PHASE_INC_B(INCB_A), .HEARTBEAT_BIT(HB_A)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .led1(led1_a), .led2(led2_a), .led8(led8_a), .ftdi_tx(tx_a)
    );

    audio_engine #(
        .CLKS_PER_BIT(CPB), .SAMPLE_DIV(SD), .PHASE_INC_A(INCA_B),
        .PHASE_INC_B(INCB_B), .HEARTBEAT_BIT(HB_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .led1(led1_b), .led2(led2_b), .led8(led8_b), .ftdi_tx(tx_b)
    );

    // Byte sent for the m-th sample tick (m = 0 is the first tick after reset).
    function automatic logic [7:0] model_byte(input logic [23:0] inca, input logic [23:0] incb,
                                              input int m);
        int unsigned mu;
        logic [23:0] pa, pb;
        int saw, sq;
        mu  = m;
        pa  = 24'(inca * mu);
        pb  = 24'(incb * mu);
        saw = int'(pa[23:16]);
        sq  = pb[23] ? 255 : 0;
        return 8'((saw + sq) / 2);
    endfunction

    // Expected outputs observed after edge c, counted from the first edge with rst_n high.
    function automatic logic exp_tx(input logic [23:0] inca, input logic [23:0] incb, input int c);
        int m, off, k;
        logic [7:0] b;
        m   = c / SD;
        off = c - m * SD;
        if (m == 0 || off >= FRAME) return 1'b1;
        k = off / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        b = model_byte(inca, incb, m - 1);
        return b[k-1];
    endfunction

    function automatic logic exp_led2(input int c);
        return (c >= SD) && ((c % SD) < FRAME);
    endfunction

    function automatic logic exp_led1(input logic [23:0] incb, input int c);
        int unsigned n;
        logic [23:0] pb;
        n  = c / SD;
        pb = 24'(incb * n);
        return pb[23];
    endfunction

    function automatic logic exp_led8(input int c, input int hb);
        int unsigned cu;
        cu = c;
        return cu[hb];
    endfunction

    task automatic next_cycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset(input int hold);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            vectors++;
            if (tx_a !== 1'b1 || led1_a !== 1'b0 || led2_a !== 1'b0 || led8_a !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_a: tx/led1/led2/led8 = %b%b%b%b, required 1000",
                         tx_a, led1_a, led2_a, led8_a);
            end
            if (tx_b !== 1'b1 || led1_b !== 1'b0 || led2_b !== 1'b0 || led8_b !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_b: tx/led1/led2/led8 = %b%b%b%b, required 1000",
                         tx_b, led1_b, led2_b, led8_b);
            end
        end
        rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic test_heartbeat();
        int edges[$];
        logic prev;
        prev = led8_a;
        while (cyc < 70) begin
            next_cycle();
            if (led8_a !== prev) edges.push_back(cyc);
            prev = led8_a;
        end
        vectors++;
        if (edges.size() != 4) begin
            miscompares++;
            $display("FAIL heartbeat_count: %0d led8 edges by cycle 70, required 4", edges.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (edges[i] != 16 * (i + 1)) begin
                    miscompares++;
                    $display("FAIL heartbeat_edge%0d: at cycle %0d, required %0d",
                             i, edges[i], 16 * (i + 1));
                end
            end
        end
    endtask

    task automatic test_bit_timing();
        int first_fall, first_rise_after, led2_on, led2_off;
        logic prev_tx, prev_led2;
        first_fall = -1; first_rise_after = -1; led2_on = -1; led2_off = -1;
        prev_tx = tx_a; prev_led2 = led2_a;
        while (cyc < SD + FRAME) begin
            next_cycle();
            if (prev_tx && !tx_a && first_fall < 0) first_fall = cyc;
            if (!prev_tx && tx_a && first_fall >= 0) first_rise_after = cyc;
            if (!prev_led2 && led2_a && led2_on < 0) led2_on = cyc;
            if (prev_led2 && !led2_a && led2_off < 0) led2_off = cyc;
            prev_tx = tx_a; prev_led2 = led2_a;
        end
        vectors++;
        if (first_fall != SD) begin
            miscompares++;
            $display("FAIL start_bit_edge: first fall at %0d, required %0d", first_fall, SD);
        end
        vectors++;
        if (first_rise_after != SD + 9 * CPB) begin
            miscompares++;
            $display("FAIL stop_bit_edge: last rise at %0d, required %0d",
                     first_rise_after, SD + 9 * CPB);
        end
        vectors++;
        if (led2_on != SD || led2_off != SD + FRAME) begin
            miscompares++;
            $display("FAIL led2_window: high %0d..%0d, required %0d..%0d",
                     led2_on, led2_off - 1, SD, SD + FRAME - 1);
        end
    endtask

    task automatic test_stream(input int upto_frame);
        logic [7:0] rx_a, rx_b, want;
        int m, off, k;
        rx_a = '0; rx_b = '0;
        while (cyc < upto_frame * SD + FRAME) begin
            next_cycle();
            vectors++;
            if (tx_a !== exp_tx(INCA_A, INCB_A, cyc)) begin
                miscompares++;
                $display("FAIL tx_a @%0d: got %b, required %b", cyc, tx_a, exp_tx(INCA_A, INCB_A, cyc));
            end
            if (tx_b !== exp_tx(INCA_B, INCB_B, cyc)) begin
                miscompares++;
                $display("FAIL tx_b @%0d: got %b, required %b", cyc, tx_b, exp_tx(INCA_B, INCB_B, cyc));
            end
            if (led2_a !== exp_led2(cyc) || led2_b !== exp_led2(cyc)) begin
                miscompares++;
                $display("FAIL led2 @%0d: got a=%b b=%b, required %b", cyc, led2_a, led2_b, exp_led2(cyc));
            end
            if (led1_a !== exp_led1(INCB_A, cyc) || led1_b !== exp_led1(INCB_B, cyc)) begin
                miscompares++;
                $display("FAIL led1 @%0d: got a=%b b=%b, required a=%b b=%b", cyc, led1_a, led1_b,
                         exp_led1(INCB_A, cyc), exp_led1(INCB_B, cyc));
            end
            if (led8_a !== exp_led8(cyc, HB_A) || led8_b !== exp_led8(cyc, HB_B)) begin
                miscompares++;
                $display("FAIL led8 @%0d: got a=%b b=%b, required a=%b b=%b", cyc, led8_a, led8_b,
                         exp_led8(cyc, HB_A), exp_led8(cyc, HB_B));
            end
            m   = cyc / SD;
            off = cyc - m * SD;
            if (m >= 1 && off < FRAME && (off % CPB) == CPB / 2) begin
                k = off / CPB;
                if (k >= 1 && k <= 8) begin
                    rx_a[k-1] = tx_a;
                    rx_b[k-1] = tx_b;
                end else if (k == 9) begin
                    vectors++;
                    want = model_byte(INCA_A, INCB_A, m - 1);
                    if (rx_a !== want) begin
                        miscompares++;
                        $display("FAIL byte_a frame %0d: got %h, required %h", m, rx_a, want);
                    end
                    vectors++;
                    want = model_byte(INCA_B, INCB_B, m - 1);
                    if (rx_b !== want) begin
                        miscompares++;
                        $display("FAIL byte_b frame %0d: got %h, required %h", m, rx_b, want);
                    end
                end
            end
        end
    endtask

    task automatic test_midframe_reset(input int drop_c, input int hold);
        while (cyc < drop_c) next_cycle();
        vectors++;
        if (led2_a !== 1'b1) begin
            miscompares++;
            $display("FAIL midframe_busy @%0d: led2 got %b, required 1", cyc, led2_a);
        end
        rst_n = 1'b0;
        next_cycle();
        vectors++;
        if (tx_a !== 1'b1 || led2_a !== 1'b0 || tx_b !== 1'b1 || led2_b !== 1'b0) begin
            miscompares++;
            $display("FAIL midframe_abort @%0d: tx a=%b b=%b led2 a=%b b=%b, required tx=1 led2=0",
                     cyc, tx_a, tx_b, led2_a, led2_b);
        end
        for (int i = 1; i < hold; i++) @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
    endtask

    initial begin
        test_reset(5);
        test_heartbeat();
        test_bit_timing();
        test_stream(6);

        test_reset(3);
        test_midframe_reset(300, 2);
        test_stream(3);

        for (int r = 0; r < 3; r++) begin
            int m;
            test_reset($urandom_range(1, 6));
            m = $urandom_range(1, 3);
            test_midframe_reset(m * SD + $urandom_range(0, FRAME - 2), $urandom_range(1, 5));
            test_stream($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
